move_cmd_sched: RTL and testbench
=================================

MOVE_CMD_SCHED -- requirements
Module: move_cmd_sched

Interface
REQ-001 Parameter DELAY_CYC, default 25_000_000: cycles from a press to the first auto-repeat (250 ms at 100 MHz).
REQ-002 Parameter REPEAT_CYC, default 5_000_000: cycles between later auto-repeats.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 kb_ready  in  1  one-cycle strobe; kb_data holds a valid PS/2 scancode byte.
REQ-006 kb_data  in  8  scancode byte from the PS/2 receiver.
REQ-007 kb_overflow  in  1  receiver FIFO overflow; the byte stream is lost.
REQ-008 cmd_ready  in  1  the game logic accepts the command this cycle.
REQ-009 cmd_valid  out  1  a command is pending.
REQ-010 cmd_code  out  3  command code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 reset.
REQ-011 held  out  5  current key-held bitmap {reset, right, left, down, up}.

Function
REQ-012 The parser FSM SHALL have 4 states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Bytes are consumed only when kb_ready=1.
REQ-013 Parser transitions:
- E0 from any state: to EXT.
- F0 from IDLE or BRK: to BRK.
- F0 from EXT or EXT_BRK: to EXT_BRK.
- Any other byte: to IDLE.
REQ-014 Make codes for arrow keys (75 up, 72 down, 6B left, 74 right) SHALL be accepted in both IDLE and EXT, so keypad arrows also work. 2D (R) SHALL be accepted only in IDLE.
REQ-015 A recognised code in IDLE/EXT SHALL set its held bit. The same code in BRK/EXT_BRK SHALL clear its held bit. Unrecognised codes SHALL change no held bit.
REQ-016 kb_overflow=1 SHALL clear held, force IDLE, and stop the repeat timer. It has priority over a same-cycle kb_ready byte.
REQ-017 The selected key SHALL be the highest-priority held bit, in the order reset > down > left > right > up. If no bit is held, there is no selected key.
REQ-018 A 0->1 transition of a held bit SHALL raise a command request for that key in the same cycle. A make byte for a key that is already held (keyboard typematic) SHALL raise no request.
REQ-019 Repeat timer:
- Reload to DELAY_CYC-1 whenever the selected key changes.
- Otherwise decrement each cycle while a non-reset key is selected.
- On reaching 0, request the selected key's command and reload to REPEAT_CYC-1.
REQ-020 The reset key SHALL never auto-repeat; it gives exactly one request per press.
REQ-021 Output buffer is one entry.
- A request with the buffer empty, or with cmd_valid&cmd_ready in the same cycle, SHALL load cmd_code and set cmd_valid on the next edge.
- Latency: a make byte at kb_ready in cycle N gives cmd_valid=1 in cycle N+1.
REQ-022 While cmd_valid=1 and cmd_ready=0, cmd_code SHALL stay stable and a new request SHALL be dropped. The exception is code 5, which SHALL overwrite the buffer.
REQ-023 A request for a key and its release in the same cycle cannot occur, because only one byte arrives per strobe. A release before acceptance SHALL NOT withdraw a buffered command.
REQ-024 cmd_valid SHALL clear on the edge after cmd_valid&cmd_ready, unless a new request loads in that cycle.
REQ-025 Timer width SHALL be $clog2(max(DELAY_CYC,REPEAT_CYC)+1) bits. Counting SHALL be unsigned and never underflow.

Reset
REQ-026 While rst=1, on each edge, the block SHALL set FSM=IDLE, held=0, timer=0, cmd_valid=0, cmd_code=0.
REQ-027 rst SHALL win over every same-cycle event. A byte sequence cut by reset is discarded; after release the first byte is parsed from IDLE.

Structure
REQ-028 A shared package kb_pkg SHALL hold:
- the scancode constants (E0, F0, 75, 72, 6B, 74, 2D),
- the cmd_code localparams,
- the parser state enum.
REQ-029 The repeat counter SHALL be a sub-module typematic_timer with ports clk, rst, load, load_val, en, expire.

Verification (DELAY_CYC=20, REPEAT_CYC=5)
REQ-030 Bytes E0 75, cmd_ready=1 -> cmd_valid=1, cmd_code=1 one cycle after the 75 strobe. Then with the key held, further code-1 pulses at +20 cycles and every 5 cycles after. Bytes E0 F0 75 -> held=0 and no further pulses.
REQ-031 Hold 6B, then press 72 while 6B is still held -> immediate code 3, then immediate code 2. The repeat timer restarts at 20 for down, and left never repeats while down is held.
REQ-032 cmd_ready=0 with 75 held for 40 cycles, then byte 2D -> cmd_code stays 1 until 2D arrives. It then becomes 5. Afterwards cmd_ready=1 -> one accept of 5, and no repeats of 5 while 2D is held.
REQ-033 Byte E0 then 2D -> held unchanged, no command. Byte F0 then kb_overflow=1 -> held=0, FSM=IDLE. A following 74 gives code 4.
REQ-034 rst=1 for 1 cycle midway through E0 F0 (after F0) -> all outputs 0. Next byte 72 -> code 2 (a press, not a release).

Source files
------------

// File: rtl/kb_pkg.sv
// Shared scancodes, command codes and parser state for the movement command scheduler.
package kb_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_RESET = 8'h2D;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_RESET = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_state_t;

  // Held-bitmap bit for a scancode: {reset, right, left, down, up}.
  function automatic logic [4:0] key_mask(input logic [7:0] b);
    logic [4:0] m;
    case (b)
      SC_UP:    m = 5'b00001;
      SC_DOWN:  m = 5'b00010;
      SC_LEFT:  m = 5'b00100;
      SC_RIGHT: m = 5'b01000;
      SC_RESET: m = 5'b10000;
      default:  m = 5'b00000;
    endcase
    return m;
  endfunction

  // Highest-priority held key: reset > down > left > right > up.
  function automatic logic [2:0] sel_code(input logic [4:0] h);
    logic [2:0] c;
    if (h[4])      c = CMD_RESET;
    else if (h[1]) c = CMD_DOWN;
    else if (h[2]) c = CMD_LEFT;
    else if (h[3]) c = CMD_RIGHT;
    else if (h[0]) c = CMD_UP;
    else           c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/typematic_timer.sv
// Down-counter for auto-repeat; expire flags a zero count while enabled.
module typematic_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = en && (count_reg == '0);

endmodule

// File: rtl/move_cmd_sched.sv
// PS/2 scancode parser turning arrow/R keys into buffered movement commands with auto-repeat.
module move_cmd_sched
  import kb_pkg::*;
#(
  parameter int DELAY_CYC  = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_ready,
  input  logic [7:0] kb_data,
  input  logic       kb_overflow,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] held
);

  localparam int MAX_CYC = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  parse_state_t state_reg, state_next;
  logic [4:0]   held_reg, held_next, key_hit, rise;
  logic [2:0]   sel_cur, sel_next, req_code;
  logic         sel_change, timer_en, expire, repeat_req, press_req, req, load_buf;
  logic         cmd_valid_reg;
  logic [2:0]   cmd_code_reg;
  logic [TW-1:0] timer_load_val;

  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    key_hit    = key_mask(kb_data);
    if (kb_overflow) begin
      state_next = ST_IDLE;
      held_next  = '0;
    end else if (kb_ready) begin
      case (state_reg)
        ST_IDLE:            held_next = held_reg | key_hit;
        ST_EXT:             held_next = held_reg | (key_hit & 5'b01111);
        ST_BRK, ST_EXT_BRK: held_next = held_reg & ~key_hit;
        default:            held_next = held_reg;
      endcase
      if (kb_data == SC_EXT)
        state_next = ST_EXT;
      else if (kb_data == SC_BRK)
        state_next = (state_reg == ST_EXT || state_reg == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      else
        state_next = ST_IDLE;
    end
  end

  assign sel_cur    = sel_code(held_reg);
  assign sel_next   = sel_code(held_next);
  assign sel_change = (sel_cur != sel_next);
  // The reset key never repeats; overflow freezes the repeat path in its own cycle.
  assign timer_en   = (sel_cur != CMD_NONE) && (sel_cur != CMD_RESET) && !kb_overflow;
  assign repeat_req = expire && !sel_change;
  assign timer_load_val = sel_change ? TW'(DELAY_CYC - 1) : TW'(REPEAT_CYC - 1);

  typematic_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (sel_change || expire),
    .load_val (timer_load_val),
    .en       (timer_en),
    .expire   (expire)
  );

  // Only one byte per strobe, so at most one bit can rise in a cycle.
  assign rise      = held_next & ~held_reg;
  assign press_req = |rise;
  assign req       = press_req || repeat_req;
  assign req_code  = press_req ? sel_code(rise) : sel_cur;
  assign load_buf  = req && (!cmd_valid_reg || cmd_ready || req_code == CMD_RESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      held_reg      <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= CMD_NONE;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      if (load_buf) begin
        cmd_valid_reg <= 1'b1;
        cmd_code_reg  <= req_code;
      end else if (cmd_valid_reg && cmd_ready) begin
        cmd_valid_reg <= 1'b0;
      end
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_code  = cmd_code_reg;
  assign held      = held_reg;

endmodule

// File: tb/tb_move_cmd_sched.sv
// Scoreboard bench: expected commands with their accept cycle are queued as bytes are sent.
module tb_move_cmd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_ready = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_overflow = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] held;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  move_cmd_sched #(.DELAY_CYC(20), .REPEAT_CYC(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_ready    (kb_ready),
    .kb_data     (kb_data),
    .kb_overflow (kb_overflow),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .held        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, output int c);
    @(posedge clk); #1;
    kb_data  = b;
    kb_ready = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    kb_ready = 1'b0;
  endtask

  task automatic expect_cmd(input int code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // One line per accepted command, checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      exp_t e;
      $display("accept cyc=%0d code=%0d held=%b", cyc, cmd_code, held);
      chk("sb_pending", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("acc_code", int'(cmd_code), e.code);
        chk("acc_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_code", int'(cmd_code), 0);
    chk("rst_held", int'(held), 0);

    // Extended up: press, delayed repeat, periodic repeats, release.
    send(8'hE0, t);
    send(8'h75, c);
    expect_cmd(1, c + 1);
    expect_cmd(1, c + 21);
    expect_cmd(1, c + 26);
    expect_cmd(1, c + 31);
    chk("held_up", int'(held), 5'b00001);
    wait_until(c + 29);
    send(8'hE0, t);
    send(8'hF0, t);
    send(8'h75, t);
    chk("held_up_rel", int'(held), 0);
    wait_until(cyc + 30);

    // Left then down: down takes over the timer, left resumes after down releases.
    send(8'h6B, c);
    expect_cmd(3, c + 1);
    send(8'h72, c);
    expect_cmd(2, c + 1);
    chk("held_ld", int'(held), 5'b00110);
    send(8'h6B, t);
    expect_cmd(2, c + 21);
    expect_cmd(2, c + 26);
    wait_until(c + 26);
    send(8'hF0, t);
    send(8'h72, t);
    chk("held_l", int'(held), 5'b00100);
    expect_cmd(3, c + 50);
    wait_until(c + 50);
    send(8'hF0, t);
    send(8'h6B, t);
    chk("held_l_rel", int'(held), 0);
    wait_until(cyc + 30);

    // Backpressure: code 1 held stable, reset key overwrites, accepted once, never repeats.
    cmd_ready = 1'b0;
    send(8'hE0, t);
    send(8'h75, c);
    wait_until(c + 20);
    chk("bp_valid", int'(cmd_valid), 1);
    chk("bp_code_mid", int'(cmd_code), 1);
    wait_until(c + 40);
    chk("bp_code_pre", int'(cmd_code), 1);
    send(8'h2D, d);
    chk("bp_code_rst", int'(cmd_code), 5);
    chk("bp_held", int'(held), 5'b10001);
    expect_cmd(5, d + 2);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    wait_until(cyc + 30);
    send(8'hF0, t);
    send(8'h2D, t);
    send(8'hE0, t);
    send(8'hF0, t);
    send(8'h75, t);
    chk("bp_held_rel", int'(held), 0);
    wait_until(cyc + 30);

    // E0 2D is ignored; overflow beats a same-cycle byte and clears everything.
    send(8'hE0, t);
    send(8'h2D, t);
    chk("ext_r_held", int'(held), 0);
    send(8'h74, c);
    expect_cmd(4, c + 1);
    send(8'hF0, t);
    @(posedge clk); #1;
    kb_overflow = 1'b1;
    kb_ready    = 1'b1;
    kb_data     = 8'h72;
    @(posedge clk); #1;
    kb_overflow = 1'b0;
    kb_ready    = 1'b0;
    chk("ovf_held", int'(held), 0);
    send(8'h74, c);
    expect_cmd(4, c + 1);
    chk("ovf_press", int'(held), 5'b01000);
    send(8'hF0, t);
    send(8'h74, t);
    chk("ovf_rel", int'(held), 0);

    // Reset in the middle of an E0 F0 release: the next byte is a fresh press.
    send(8'h6B, c);
    expect_cmd(3, c + 1);
    send(8'hE0, t);
    send(8'hF0, t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_held", int'(held), 0);
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_code", int'(cmd_code), 0);
    send(8'h72, c);
    expect_cmd(2, c + 1);
    chk("post_rst_held", int'(held), 5'b00010);
    send(8'hF0, t);
    send(8'h72, t);
    chk("post_rst_rel", int'(held), 0);
    wait_until(cyc + 10);

    chk("sb_empty", int'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
